// File: rtl/uart_pkg.sv
// Shared types and constants for the UART register-access responder.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_DATA = 3'd1,
      ST_REG_ACC   = 3'd2,
      ST_SEND      = 3'd3,
      ST_WAIT_TX   = 3'd4
   } state_t;

   // Source of the response byte, chosen before the uniform decode cycle.
   typedef enum logic [1:0] {
      RSP_READ = 2'd0,
      RSP_ACK  = 2'd1,
      RSP_NAK  = 2'd2
   } resp_t;

   localparam int WR_BIT   = 7;
   localparam int ADDR_MSB = 3;

   localparam logic [7:0] ACK_DEFAULT = 8'hAA;
   localparam logic [7:0] NAK_DEFAULT = 8'hEE;

   function automatic logic cmd_reserved_set(input logic [7:0] cmd);
      return (cmd[6:4] != 3'd0);
   endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Clearable, enabled up-counter that flags the last cycle of a TIMEOUT_CYC window.
module uart_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYC = 32'd100
)(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int unsigned W = $clog2(TIMEOUT_CYC + 32'd1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic         at_end_s;

   assign at_end_s = (cnt_q == W'(TIMEOUT_CYC - 32'd1));
   assign tc_o     = en_i && at_end_s;

   // Counter holds at the terminal value until cleared.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !at_end_s) begin
         cnt_d = cnt_q + W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_reg_responder.sv
// Register-access responder behind a UART: decodes one/two-byte commands,
// drives a 16 x 8 register bus and answers with a single response byte.
module uart_reg_responder
   import uart_pkg::*;
#(
   parameter int unsigned SYS_CLK       = 32'd50_000_000,
   parameter int unsigned BAUD          = 32'd115_200,
   parameter int unsigned TIMEOUT_BYTES = 32'd4,
   parameter logic [7:0]  ACK_CODE      = ACK_DEFAULT,
   parameter logic [7:0]  NAK_CODE      = NAK_DEFAULT
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_done,
   input  logic [8:0] rx_data,
   input  logic       parity_error,
   input  logic       jitter_error,
   input  logic       tx_done,
   output logic       send_en,
   output logic [8:0] tx_data,
   output logic [3:0] reg_addr,
   output logic       reg_we,
   output logic [7:0] reg_wdata,
   input  logic [7:0] reg_rdata,
   output logic       busy,
   output logic [7:0] drop_cnt
);

   localparam int unsigned TIMEOUT_CYC =
      32'((64'(TIMEOUT_BYTES) * 64'd10 * 64'(SYS_CLK)) / 64'(BAUD));

   state_t     state_q, state_d;
   resp_t      kind_q, kind_d;
   logic       send_en_q, send_en_d;
   logic [8:0] tx_data_q, tx_data_d;
   logic [3:0] reg_addr_q, reg_addr_d;
   logic       reg_we_q, reg_we_d;
   logic [7:0] reg_wdata_q, reg_wdata_d;
   logic       busy_q;
   logic [7:0] drop_cnt_q, drop_cnt_d;

   logic       rx_err_s;
   logic [7:0] rx_byte_s;
   logic       unused_rx_msb_s;
   logic       tmr_clr_s, tmr_en_s, tmr_tc_s;

   assign rx_err_s        = parity_error | jitter_error;
   assign rx_byte_s       = rx_data[7:0];
   assign unused_rx_msb_s = rx_data[8];

   uart_timeout_cnt #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .clr_i  (tmr_clr_s),
      .en_i   (tmr_en_s),
      .tc_o   (tmr_tc_s)
   );

   // Every outcome (read, ACK, NAK) passes through REG_ACC, so send_en always
   // lands two cycles after the deciding byte.
   always_comb begin
      state_d     = state_q;
      kind_d      = kind_q;
      send_en_d   = 1'b0;
      tx_data_d   = tx_data_q;
      reg_addr_d  = reg_addr_q;
      reg_we_d    = 1'b0;
      reg_wdata_d = reg_wdata_q;
      drop_cnt_d  = drop_cnt_q;
      tmr_clr_s   = 1'b0;
      tmr_en_s    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_done) begin
               if (rx_err_s || cmd_reserved_set(rx_byte_s)) begin
                  kind_d  = RSP_NAK;
                  state_d = ST_REG_ACC;
               end else if (rx_byte_s[WR_BIT]) begin
                  reg_addr_d = rx_byte_s[ADDR_MSB:0];
                  tmr_clr_s  = 1'b1;
                  state_d    = ST_WAIT_DATA;
               end else begin
                  reg_addr_d = rx_byte_s[ADDR_MSB:0];
                  kind_d     = RSP_READ;
                  state_d    = ST_REG_ACC;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_DATA: begin
            tmr_en_s = 1'b1;
            if (rx_done) begin
               if (rx_err_s) begin
                  kind_d = RSP_NAK;
               end else begin
                  reg_we_d    = 1'b1;
                  reg_wdata_d = rx_byte_s;
                  kind_d      = RSP_ACK;
               end
               state_d = ST_REG_ACC;
            end else if (tmr_tc_s) begin
               kind_d  = RSP_NAK;
               state_d = ST_REG_ACC;
            end else begin
               state_d = ST_WAIT_DATA;
            end
         end
         ST_REG_ACC: begin
            case (kind_q)
               RSP_READ: tx_data_d = {1'b0, reg_rdata};
               RSP_ACK:  tx_data_d = {1'b0, ACK_CODE};
               RSP_NAK:  tx_data_d = {1'b0, NAK_CODE};
               default:  tx_data_d = {1'b0, NAK_CODE};
            endcase
            send_en_d = 1'b1;
            state_d   = ST_SEND;
         end
         ST_SEND: begin
            state_d = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            if (tx_done) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_TX;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (rx_done && (state_q inside {ST_REG_ACC, ST_SEND, ST_WAIT_TX})
          && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         kind_q      <= RSP_NAK;
         send_en_q   <= 1'b0;
         tx_data_q   <= 9'd0;
         reg_addr_q  <= 4'd0;
         reg_we_q    <= 1'b0;
         reg_wdata_q <= 8'd0;
         busy_q      <= 1'b0;
         drop_cnt_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         send_en_q   <= send_en_d;
         tx_data_q   <= tx_data_d;
         reg_addr_q  <= reg_addr_d;
         reg_we_q    <= reg_we_d;
         reg_wdata_q <= reg_wdata_d;
         busy_q      <= (state_d != ST_IDLE);
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign send_en   = send_en_q;
   assign tx_data   = tx_data_q;
   assign reg_addr  = reg_addr_q;
   assign reg_we    = reg_we_q;
   assign reg_wdata = reg_wdata_q;
   assign busy      = busy_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed bench for uart_reg_responder with a cycle-scheduled reference model.
module tb_uart_reg_responder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_done = 1'b0;
   logic [8:0] rx_data = 9'd0;
   logic       parity_error = 1'b0;
   logic       jitter_error = 1'b0;
   logic       tx_done = 1'b0;
   logic       send_en;
   logic [8:0] tx_data;
   logic [3:0] reg_addr;
   logic       reg_we;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;
   logic       busy;
   logic [7:0] drop_cnt;

   uart_reg_responder #(
      .SYS_CLK       (32'd1_000_000),
      .BAUD          (32'd100_000),
      .TIMEOUT_BYTES (32'd1),
      .ACK_CODE      (8'hAA),
      .NAK_CODE      (8'hEE)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_done      (rx_done),
      .rx_data      (rx_data),
      .parity_error (parity_error),
      .jitter_error (jitter_error),
      .tx_done      (tx_done),
      .send_en      (send_en),
      .tx_data      (tx_data),
      .reg_addr     (reg_addr),
      .reg_we       (reg_we),
      .reg_wdata    (reg_wdata),
      .reg_rdata    (reg_rdata),
      .busy         (busy),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   // Register file on the far side of the bus.
   logic [7:0] regs [16];
   assign reg_rdata = regs[reg_addr];
   always @(posedge clk) if (reg_we) regs[reg_addr] <= reg_wdata;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: expected output changes keyed by cycle number.
   logic [8:0] u_tx   [int];
   logic [3:0] u_addr [int];
   logic [7:0] u_wd   [int];
   logic [7:0] u_drop [int];
   logic       u_busy [int];
   bit         e_send [int];
   bit         e_we   [int];
   logic [7:0] mem_m  [16];
   logic [7:0] drop_m = 8'd0;
   logic [3:0] pend_addr = 4'd0;

   logic [8:0] m_tx = 9'd0;
   logic [3:0] m_addr = 4'd0;
   logic [7:0] m_wd = 8'd0;
   logic [7:0] m_drop = 8'd0;
   logic       m_busy = 1'b0;
   bit         chk_on = 1'b0;

   logic [8:0] last_tx = 9'd0;
   int         last_send = 0;
   int         we_cnt = 0;
   logic [3:0] last_we_addr = 4'd0;
   logic [7:0] last_we_data = 8'd0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!chk_on) begin
         m_tx = 9'd0; m_addr = 4'd0; m_wd = 8'd0; m_drop = 8'd0; m_busy = 1'b0;
      end else begin
         if (u_tx.exists(cyc))   m_tx   = u_tx[cyc];
         if (u_addr.exists(cyc)) m_addr = u_addr[cyc];
         if (u_wd.exists(cyc))   m_wd   = u_wd[cyc];
         if (u_drop.exists(cyc)) m_drop = u_drop[cyc];
         if (u_busy.exists(cyc)) m_busy = u_busy[cyc];
         check("send_en",   32'(send_en),   32'(e_send.exists(cyc)));
         check("reg_we",    32'(reg_we),    32'(e_we.exists(cyc)));
         check("tx_data",   32'(tx_data),   32'(m_tx));
         check("reg_addr",  32'(reg_addr),  32'(m_addr));
         check("reg_wdata", 32'(reg_wdata), 32'(m_wd));
         check("busy",      32'(busy),      32'(m_busy));
         check("drop_cnt",  32'(drop_cnt),  32'(m_drop));
         if (send_en) begin last_tx = tx_data; last_send = cyc; end
         if (reg_we) begin we_cnt++; last_we_addr = reg_addr; last_we_data = reg_wdata; end
      end
   end

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic wait_until(input int c);
      while (cyc < c) begin @(posedge clk); #1; end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit perr, input bit jerr, output int n);
      rx_done = 1'b1; rx_data = {1'b0, b}; parity_error = perr; jitter_error = jerr;
      n = cyc;
      @(posedge clk); #1;
      rx_done = 1'b0; parity_error = 1'b0; jitter_error = 1'b0;
   endtask

   task automatic cmd(input logic [7:0] b, input bit perr, input bit jerr, output int n, output int s);
      send_byte(b, perr, jerr, n);
      u_busy[n+1] = 1'b1;
      s = -1;
      if (perr || jerr || b[6:4] != 3'd0) begin
         e_send[n+2] = 1'b1; u_tx[n+2] = {1'b0, 8'hEE}; s = n + 2;
      end else begin
         u_addr[n+1] = b[3:0];
         pend_addr = b[3:0];
         if (!b[7]) begin
            e_send[n+2] = 1'b1; u_tx[n+2] = {1'b0, mem_m[b[3:0]]}; s = n + 2;
         end
      end
   endtask

   task automatic wdata(input logic [7:0] d, input bit jerr, output int m, output int s);
      send_byte(d, 1'b0, jerr, m);
      s = m + 2;
      e_send[s] = 1'b1;
      if (jerr) begin
         u_tx[s] = {1'b0, 8'hEE};
      end else begin
         e_we[m+1] = 1'b1; u_wd[m+1] = d; mem_m[pend_addr] = d;
         u_tx[s] = {1'b0, 8'hAA};
      end
   endtask

   task automatic close_tx(input int s, input int d);
      int t;
      wait_until(s + d);
      tx_done = 1'b1; t = cyc;
      @(posedge clk); #1;
      tx_done = 1'b0;
      u_busy[t+1] = 1'b0;
   endtask

   task automatic drop_byte(input logic [7:0] b);
      int c;
      send_byte(b, 1'b0, 1'b0, c);
      drop_m = (drop_m == 8'hFF) ? 8'hFF : drop_m + 8'd1;
      u_drop[c+1] = drop_m;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_send_en"},   32'(send_en),   32'd0);
      check({tag, "_tx_data"},   32'(tx_data),   32'd0);
      check({tag, "_reg_addr"},  32'(reg_addr),  32'd0);
      check({tag, "_reg_we"},    32'(reg_we),    32'd0);
      check({tag, "_reg_wdata"}, 32'(reg_wdata), 32'd0);
      check({tag, "_busy"},      32'(busy),      32'd0);
      check({tag, "_drop_cnt"},  32'(drop_cnt),  32'd0);
   endtask

   task automatic mid_reset(input string tag);
      chk_on = 1'b0;
      #1 rst_n = 1'b0;
      #1 check_reset_vals(tag);
      u_tx.delete(); u_addr.delete(); u_wd.delete(); u_drop.delete();
      u_busy.delete(); e_send.delete(); e_we.delete();
      drop_m = 8'd0;
      @(posedge clk); #1;
      rst_n = 1'b1; chk_on = 1'b1;
   endtask

   initial begin
      int n, m, s;
      for (int i = 0; i < 16; i++) begin
         regs[i] = 8'h10 + 8'(i);
         mem_m[i] = 8'h10 + 8'(i);
      end
      regs[5] = 8'h3C; mem_m[5] = 8'h3C;

      #3 check_reset_vals("por");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; chk_on = 1'b1;

      // Read addr 5
      cmd(8'h05, 1'b0, 1'b0, n, s);
      close_tx(s, 2);
      check("rd_tx", 32'(last_tx), 32'h03C);
      check("rd_lat", 32'(last_send - n), 32'd2);
      check("rd_no_we", 32'(we_cnt), 32'd0);

      // Write 0x77 to addr A; a tx_done during SEND must be ignored
      cmd(8'h8A, 1'b0, 1'b0, n, s);
      wdata(8'h77, 1'b0, m, s);
      wait_until(s);
      tx_done = 1'b1; @(posedge clk); #1; tx_done = 1'b0;
      close_tx(s, 3);
      check("wr_addr", 32'(last_we_addr), 32'hA);
      check("wr_data", 32'(last_we_data), 32'h77);
      check("wr_tx", 32'(last_tx), 32'h0AA);
      check("wr_cnt", 32'(we_cnt), 32'd1);
      check("wr_lat", 32'(last_send - m), 32'd2);

      // Parity error on command byte
      cmd(8'h05, 1'b1, 1'b0, n, s);
      close_tx(s, 1);
      check("par_tx", 32'(last_tx), 32'h0EE);

      // Jitter error on write data byte
      cmd(8'h83, 1'b0, 1'b0, n, s);
      wdata(8'h99, 1'b1, m, s);
      close_tx(s, 2);
      check("jit_tx", 32'(last_tx), 32'h0EE);
      check("jit_no_we", 32'(we_cnt), 32'd1);

      // Reserved bits set
      cmd(8'h35, 1'b0, 1'b0, n, s);
      close_tx(s, 1);
      check("rsv_tx", 32'(last_tx), 32'h0EE);

      // Timeout with no data byte
      cmd(8'h81, 1'b0, 1'b0, n, s);
      s = n + 102;
      e_send[s] = 1'b1; u_tx[s] = {1'b0, 8'hEE};
      close_tx(s, 2);
      check("to_tx", 32'(last_tx), 32'h0EE);
      check("to_lat", 32'(last_send - n), 32'd102);
      check("to_no_we", 32'(we_cnt), 32'd1);

      // Data byte arrives in the terminal cycle
      cmd(8'h81, 1'b0, 1'b0, n, s);
      wait_until(n + 100);
      wdata(8'h5E, 1'b0, m, s);
      close_tx(s, 2);
      check("to_ack_tx", 32'(last_tx), 32'h0AA);
      check("to_ack_data", 32'(last_we_data), 32'h5E);
      check("to_ack_lat", 32'(last_send - n), 32'd102);

      // Overrun: bytes in SEND and WAIT_TX are dropped
      cmd(8'h05, 1'b0, 1'b0, n, s);
      wait_until(s);
      for (int i = 0; i < 3; i++) drop_byte(8'hF0 + 8'(i));
      close_tx(s, 5);
      check("ovr_drop", 32'(drop_cnt), 32'd3);
      check("ovr_idle", 32'(busy), 32'd0);

      // Saturation at 255
      cmd(8'h02, 1'b0, 1'b0, n, s);
      wait_until(s + 1);
      for (int i = 0; i < 256; i++) drop_byte(8'(i));
      close_tx(s, 1);
      check("sat_drop", 32'(drop_cnt), 32'd255);

      // Reset during WAIT_DATA, then read back addr A
      cmd(8'h82, 1'b0, 1'b0, n, s);
      wait_until(n + 5);
      mid_reset("rst_wd");
      cmd(8'h0A, 1'b0, 1'b0, n, s);
      close_tx(s, 2);
      check("rst_wd_rd", 32'(last_tx), 32'h077);

      // Reset during WAIT_TX, then read addr 3
      cmd(8'h05, 1'b0, 1'b0, n, s);
      wait_until(s + 2);
      mid_reset("rst_wt");
      cmd(8'h03, 1'b0, 1'b0, n, s);
      close_tx(s, 2);
      check("rst_wt_rd", 32'(last_tx), 32'h013);
      check("final_we", 32'(we_cnt), 32'd2);

      repeat (3) @(posedge clk);
      #1 chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
